// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
//
// Handshake: start is a request accepted only while the block is idle
// (busy = 0 and done = 0). On the accepting edge a and b are captured.
// The caller need not hold them afterwards. A start seen while busy or
// done is dropped, not queued. done pulses for one cycle when diff/borrow
// are updated. Those outputs then hold until the next done or reset.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic             br_next;
  logic             d;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs plus the stored borrow.
  assign d       = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  // New result bit enters at the MSB so that after WIDTH shifts the LSB
  // computed first has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d;
    end else begin : g_res_wn
      assign res_next = {d, res_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs decoded straight from state.
  always_comb begin
    state_next = state;
    busy       = (state == SHIFT);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shift, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff   <= res_next;
            borrow <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 main instance, WIDTH=1 side
// instance). Inputs are driven and outputs sampled on the falling edge.
module tb_serial_subtractor;

  localparam int W = 8;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  logic start1 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic busy1, done1, diff1, borrow1;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  // Driver: one start pulse, then wait (bounded) for done.
  // lat = index of the done cycle counted from the cycle after acceptance,
  // -1 if done never came.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] rd, output logic rb,
                       output int nbusy, output int lat, output bit held);
    logic [W-1:0] prev;
    @(negedge clk);
    prev  = diff;
    start = 1'b1; a_in = av; b_in = bv;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; lat = -1; held = 1'b1;
    for (int i = 0; i < W + 6; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
      if (diff !== prev) held = 1'b0;
      @(negedge clk);
    end
    rd = diff; rb = borrow;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (diff !== 8'h00)  begin errors++; $display("FAIL reset_diff got %h exp 00", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] rd; logic rb; int nb, lat; bit held;
    do_op(8'd100, 8'd37, rd, rb, nb, lat, held);
    checks++; if (lat !== W)     begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, W); end
    checks++; if (nb !== W)      begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", nb, W); end
    checks++; if (rd !== 8'h3F)  begin errors++; $display("FAIL basic_diff got %h exp 3f", rd); end
    checks++; if (rb !== 1'b0)   begin errors++; $display("FAIL basic_borrow got %b exp 0", rb); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL basic_hold got %b exp 1", held); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{8'd5,  8'hFF, 8'h00};
    logic [W-1:0] vb [3] = '{8'd9,  8'hFF, 8'h01};
    logic [W-1:0] ed [3] = '{8'hFC, 8'h00, 8'hFF};
    logic         eb [3] = '{1'b1,  1'b0,  1'b1};
    logic [W-1:0] rd; logic rb; int nb, lat; bit held;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], rd, rb, nb, lat, held);
      checks++; if (rd !== ed[i])  begin errors++; $display("FAIL vec%0d_diff got %h exp %h", i, rd, ed[i]); end
      checks++; if (rb !== eb[i])  begin errors++; $display("FAIL vec%0d_borrow got %b exp %b", i, rb, eb[i]); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL vec%0d_hold got %b exp 1", i, held); end
    end
  endtask

  // Entered with diff=FF, borrow=1 left by test_vectors.
  task automatic test_reset_mid();
    int ndone, nbusy;
    logic [W-1:0] rd; logic rb; int nb, lat; bit held;
    @(negedge clk);
    start = 1'b1; a_in = 8'd77; b_in = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (diff !== 8'h00)  begin errors++; $display("FAIL rstmid_diff got %h exp 00", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL rstmid_borrow got %b exp 0", borrow); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", ndone); end
    checks++; if (nbusy !== 0) begin errors++; $display("FAIL rstmid_no_busy got %0d exp 0", nbusy); end
    do_op(8'd30, 8'd40, rd, rb, nb, lat, held);
    checks++; if (rd !== 8'hF6) begin errors++; $display("FAIL rstmid_after_diff got %h exp f6", rd); end
    checks++; if (rb !== 1'b1)  begin errors++; $display("FAIL rstmid_after_borrow got %b exp 1", rb); end
  endtask

  task automatic test_ignore_start();
    int ndone, nbusy, nbusy_after, first_done;
    logic [W-1:0] rd; logic rb;
    rd = '0; rb = 1'b0;
    @(negedge clk);
    start = 1'b1; a_in = 8'd200; b_in = 8'd50;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0; nbusy_after = 0; first_done = -1;
    for (int i = 0; i < W + 10; i++) begin
      if (done) begin
        ndone++;
        if (first_done < 0) begin first_done = i; rd = diff; rb = borrow; end
      end
      if (busy) begin
        if (first_done < 0) nbusy++;
        else nbusy_after++;
      end
      if (i == 2) begin start = 1'b1; a_in = 8'd1; b_in = 8'd2; end
      if (i == 3) begin start = 1'b0; a_in = 8'd7; b_in = 8'd250; end
      @(negedge clk);
    end
    checks++; if (ndone !== 1)      begin errors++; $display("FAIL ign_done_count got %0d exp 1", ndone); end
    checks++; if (first_done !== W) begin errors++; $display("FAIL ign_latency got %0d exp %0d", first_done, W); end
    checks++; if (nbusy !== W)      begin errors++; $display("FAIL ign_busy_cycles got %0d exp %0d", nbusy, W); end
    checks++; if (nbusy_after !== 0) begin errors++; $display("FAIL ign_requeued got %0d exp 0", nbusy_after); end
    checks++; if (rd !== 8'd150)    begin errors++; $display("FAIL ign_diff got %0d exp 150", rd); end
    checks++; if (rb !== 1'b0)      begin errors++; $display("FAIL ign_borrow got %b exp 0", rb); end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    bit stable;
    stable = 1'b1;
    @(negedge clk);
    start = 1'b1; a_in = 8'd9; b_in = 8'd3;
    @(negedge clk);
    for (int i = 0; i < 35; i++) begin
      if (done) begin
        pos.push_back(i);
        checks++; if (diff !== 8'd6) begin errors++; $display("FAIL b2b_diff got %0d exp 6", diff); end
      end
      if (pos.size() > 0 && diff !== 8'd6) stable = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    checks++; if (pos.size() !== 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", pos.size()); end
    checks++; if (pos.size() > 0 && pos[0] !== W) begin errors++; $display("FAIL b2b_first got %0d exp %0d", pos[0], W); end
    for (int i = 1; i < pos.size(); i++) begin
      checks++; if (pos[i] - pos[i-1] !== W + 2) begin errors++; $display("FAIL b2b_period got %0d exp %0d", pos[i] - pos[i-1], W + 2); end
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_stable got %b exp 1", stable); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] av, bv, rd; logic rb; int nb, lat; bit held;
    logic [W:0] exp_v;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0: begin av = 8'h00; bv = 8'hFF; end
        1: begin av = 8'hFF; bv = 8'h00; end
        2: begin av = 8'h80; bv = 8'h7F; end
        3: begin av = 8'h7F; bv = 8'h80; end
        default: begin av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255)); end
      endcase
      exp_q.push_back({(av < bv), 8'(av - bv)});
      do_op(av, bv, rd, rb, nb, lat, held);
      exp_v = exp_q.pop_front();
      checks++;
      if (lat !== W || {rb, rd} !== exp_v) begin
        errors++;
        $display("FAIL sweep a=%h b=%h got %b_%h lat %0d exp %b_%h lat %0d",
                 av, bv, rb, rd, lat, exp_v[W], exp_v[W-1:0], W);
      end
    end
  endtask

  task automatic test_width1();
    logic va [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic vb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic eb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int nbusy, lat;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = va[k]; b1 = vb[k];
      @(negedge clk);
      start1 = 1'b0;
      nbusy = 0; lat = -1;
      for (int i = 0; i < 6; i++) begin
        if (done1) begin lat = i; break; end
        if (busy1) nbusy++;
        @(negedge clk);
      end
      checks++; if (lat !== 1 || nbusy !== 1) begin errors++; $display("FAIL w1_timing%0d got lat %0d busy %0d exp lat 1 busy 1", k, lat, nbusy); end
      checks++; if (diff1 !== ed[k])   begin errors++; $display("FAIL w1_diff%0d got %b exp %b", k, diff1, ed[k]); end
      checks++; if (borrow1 !== eb[k]) begin errors++; $display("FAIL w1_borrow%0d got %b exp %b", k, borrow1, eb[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_width1();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #400000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
